cache_way_ctrl: RTL and testbench
=================================

Name: cache_way_ctrl

Overview:
- Lookup/replacement controller for the 2-way set-associative cache.
- Holds per-set tag, valid and LRU state and performs the tag compare.
- Sequences line fills from memory with a req/ack handshake.
- Drives the way-select of the 2:1 way muxes (way_sel) and the per-way data-array write enables; keeps saturating hit/miss counters.

Parameters:
- INDEX_BITS, 3, set index width; number of sets = 2**INDEX_BITS.
- TAG_BITS, 3, tag width per way.
- CNT_BITS, 16, width of hit/miss statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  controller can accept a request
- req_addr  in  TAG_BITS+INDEX_BITS  {tag, index}
- req_write  in  1  1 = write, 0 = read
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  request hit; valid with resp_valid
- way_sel  out  1  select for the way data muxes (0 = way0, 1 = way1)
- data_we0  out  1  write enable, way0 data array
- data_we1  out  1  write enable, way1 data array
- mem_req  out  1  line fetch request
- mem_addr  out  TAG_BITS+INDEX_BITS  fetch address
- mem_ack  in  1  fetch data present this cycle
- hit_count  out  CNT_BITS  saturating hit counter
- miss_count  out  CNT_BITS  saturating miss counter

Behaviour:
- Reset (async, rst_n=0): state IDLE; all valid bits 0; all LRU bits 0; tags 0.
- Reset values of outputs: req_ready 0, resp_valid 0, resp_hit 0, way_sel 0, data_we0/1 0, mem_req 0, mem_addr 0, both counters 0.
- req_ready is registered: it goes to 1 on the first edge after reset release and is 1 exactly while in IDLE.
- Accept: a request is accepted when req_valid & req_ready are both 1 at an edge. addr and write are latched; state -> LOOKUP.
- LOOKUP (exactly 1 cycle):
  - hitN = valid[N][idx] & (tag[N][idx] == tag).
  - Both hitN set cannot occur by construction; if it does, way0 wins.
  - Hit: way_sel <= hit way; LRU[idx] <= other way; hit_count++; -> RESP.
  - Miss: victim = way0 if invalid, else way1 if invalid, else LRU[idx].
  - On miss: way_sel <= victim; miss_count++; mem_req <= 1; mem_addr <= latched addr; -> FILL.
- FILL:
  - mem_req is held at 1 and mem_addr held stable until mem_ack.
  - In the ack cycle: data_we[victim] = 1 for that cycle only; tag[victim][idx] <= tag; valid <= 1; LRU[idx] <= other way.
  - Next state after ack: mem_req 0, -> RESP.
  - mem_ack outside FILL is ignored.
- RESP (exactly 1 cycle):
  - resp_valid = 1; resp_hit = 1 for a hit, 0 for a miss; way_sel held.
  - If the request is a write, data_we[way_sel] = 1 in this cycle (write-allocate).
  - Next state: IDLE; req_ready returns to 1 on the next edge.
- Latency from accept edge to resp_valid:
  - hit: 2 cycles.
  - miss: 3 cycles + mem_ack wait.
- One outstanding request at a time. No request is accepted in LOOKUP, FILL or RESP; req_valid held during those states is accepted only once back in IDLE.
- Only one of data_we0/data_we1 may be high in any cycle.
- Counters saturate at all-ones and never wrap.
- Reset mid-FILL: all state clears immediately; mem_req drops asynchronously; the line is not installed.

Test Plan:
- Cold read addr 6'b101_011 -> miss; mem_req=1, mem_addr=6'h2B; ack after 4 cycles -> data_we0 pulses, resp_valid with resp_hit=0, way_sel=0; miss_count=1.
- Repeat read 6'b101_011 -> resp_valid 2 cycles after accept, resp_hit=1, way_sel=0, no mem_req; hit_count=1.
- Read 6'b110_011 (same set, new tag) -> fill goes to way1 (invalid first); then read 6'b101_011 hits way0, so LRU=1; then read 6'b111_011 evicts way1 (data_we1 pulses).
- Write hit 6'b101_011 -> data_we0 single pulse in the RESP cycle only; write miss 6'b010_000 -> data_we0 in the ack cycle and again in the RESP cycle.
- Hold req_valid continuously -> req_ready low from LOOKUP through RESP; exactly one accept per transaction.
- Assert rst_n=0 during FILL -> mem_req 0 immediately; after release the same address misses; counters read 0.

Source files
------------

// File: rtl/cache_way_ctrl.sv
// Lookup/replacement controller for a 2-way set-associative cache: tag/valid/LRU
// storage, tag compare, req/ack line fill sequencing and hit/miss statistics.
module cache_way_ctrl #(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 3,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [TAG_BITS+INDEX_BITS-1:0] req_addr,
  input  logic                           req_write,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic                           way_sel,
  output logic                           data_we0,
  output logic                           data_we1,
  output logic                           mem_req,
  output logic [TAG_BITS+INDEX_BITS-1:0] mem_addr,
  input  logic                           mem_ack,
  output logic [CNT_BITS-1:0]            hit_count,
  output logic [CNT_BITS-1:0]            miss_count
);

  localparam int unsigned SETS      = 1 << INDEX_BITS;
  localparam int unsigned ADDR_BITS = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic                   req_ready_d, resp_valid_d, resp_hit_d, way_sel_d;
  logic                   mem_req_d;
  logic [ADDR_BITS-1:0]   mem_addr_d;
  logic                   hit_inc, miss_inc, install, lru_upd, lru_val;

  logic [TAG_BITS-1:0]    tag0_q [SETS];
  logic [TAG_BITS-1:0]    tag1_q [SETS];
  logic [SETS-1:0]        valid0_q, valid1_q, lru_q;

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit0, hit1, victim;

  assign idx    = addr_q[INDEX_BITS-1:0];
  assign tag    = addr_q[ADDR_BITS-1:INDEX_BITS];
  assign hit0   = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1   = valid1_q[idx] && (tag1_q[idx] == tag);
  // Fill empty ways first; lru_q holds the way to evict next.
  assign victim = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

  // Data-array strobes must coincide with the fill data beat, so they are decoded from state.
  logic fill_we, resp_we;
  assign fill_we  = (state_q == FILL) && mem_ack;
  assign resp_we  = (state_q == RESP) && write_q;
  assign data_we0 = (fill_we || resp_we) && !way_sel;
  assign data_we1 = (fill_we || resp_we) &&  way_sel;

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    way_sel_d  = way_sel;
    resp_hit_d = resp_hit;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    install    = 1'b0;
    lru_upd    = 1'b0;
    lru_val    = lru_q[idx];
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          write_d = req_write;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          way_sel_d  = !hit0;
          resp_hit_d = 1'b1;
          lru_upd    = 1'b1;
          lru_val    = hit0;
          hit_inc    = 1'b1;
          state_d    = RESP;
        end else begin
          way_sel_d  = victim;
          resp_hit_d = 1'b0;
          miss_inc   = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          install   = 1'b1;
          lru_upd   = 1'b1;
          lru_val   = !way_sel;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      way_sel    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_hit   <= resp_hit_d;
      way_sel    <= way_sel_d;
      mem_req    <= mem_req_d;
      mem_addr   <= mem_addr_d;
      if (hit_inc && (hit_count != '1))
        hit_count <= hit_count + CNT_BITS'(1);
      if (miss_inc && (miss_count != '1))
        miss_count <= miss_count + CNT_BITS'(1);
    end
  end

  // Per-set tag, valid and LRU storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag0_q[i] <= '0;
        tag1_q[i] <= '0;
      end
    end else begin
      if (install) begin
        if (way_sel) begin
          tag1_q[idx]   <= tag;
          valid1_q[idx] <= 1'b1;
        end else begin
          tag0_q[idx]   <= tag;
          valid0_q[idx] <= 1'b1;
        end
      end
      if (lru_upd)
        lru_q[idx] <= lru_val;
    end
  end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Scoreboard bench for cache_way_ctrl: expected responses queued at accept,
// popped and compared when resp_valid appears.
module tb_cache_way_ctrl;

  localparam int unsigned IB = 3;
  localparam int unsigned TB = 3;
  localparam int unsigned CB = 16;
  localparam int unsigned AB = IB + TB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AB-1:0] req_addr;
  logic          resp_valid, resp_hit, way_sel, data_we0, data_we1;
  logic          mem_req, mem_ack;
  logic [AB-1:0] mem_addr;
  logic [CB-1:0] hit_count, miss_count;

  cache_way_ctrl #(.INDEX_BITS(IB), .TAG_BITS(TB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .way_sel(way_sel),
    .data_we0(data_we0), .data_we1(data_we1),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit;
    logic way;
    int   acc;
    int   lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0, accepts = 0, n_req = 0;
  int exp_hits = 0, exp_miss = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (rst_n && req_valid && req_ready) accepts++;

  // Latency = edges from the accept edge to the edge that samples resp_valid.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_hit", resp_hit, mon_e.hit);
        chk("resp_way_sel", way_sel, mon_e.way);
        chk("resp_latency", cyc - mon_e.acc + 1, mon_e.lat);
      end
    end
  end

  task automatic do_req(input logic [AB-1:0] a, input logic w, input logic eh,
                        input logic ew, input int dly, input bit keep);
    int  k, guard, n_we0, n_we1, n_mr, addr_bad, rdy_bad, both;
    bit  done;
    k = 0; n_we0 = 0; n_we1 = 0; n_mr = 0; addr_bad = 0; rdy_bad = 0; both = 0;
    done = 1'b0; guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", guard < 50, 1);
    req_valid = 1'b1; req_addr = a; req_write = w;
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    n_req++;
    sbq.push_back('{hit: eh, way: ew, acc: cyc, lat: (eh ? 2 : 3 + dly)});
    if (eh) exp_hits++; else exp_miss++;
    guard = 0;
    while (!done && guard < 100) begin
      if (req_ready) rdy_bad++;
      if (mem_req) begin
        n_mr++;
        if (mem_addr !== a) addr_bad++;
        mem_ack = (k == dly);
        k++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (data_we0) n_we0++;
      if (data_we1) n_we1++;
      if (data_we0 && data_we1) both++;
      if (mem_ack) chk("ack_cycle_we", {data_we1, data_we0}, ew ? 2 : 1);
      if (resp_valid) done = 1'b1;
      else begin
        @(negedge clk);
        guard++;
      end
    end
    mem_ack = 1'b0;
    chk("resp_seen", done, 1);
    chk("mem_req_cycles", n_mr, eh ? 0 : dly + 1);
    chk("mem_addr_stable_bad", addr_bad, 0);
    chk("ready_low_busy_bad", rdy_bad, 0);
    chk("we_both_high", both, 0);
    chk("we0_pulses", n_we0, ew ? 0 : ((eh ? 0 : 1) + (w ? 1 : 0)));
    chk("we1_pulses", n_we1, ew ? ((eh ? 0 : 1) + (w ? 1 : 0)) : 0);
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_miss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int guard;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst_outs", {req_ready, resp_valid, resp_hit, way_sel, data_we0, data_we1, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", req_ready, 1);

    // mem_ack in IDLE must have no effect
    mem_ack = 1'b1;
    #1 chk("stray_ack_we", {data_we1, data_we0}, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_state", {mem_req, resp_valid, req_ready}, 1);

    do_req(6'h2B, 1'b0, 1'b0, 1'b0, 4, 1'b0);  // cold miss -> way0
    do_req(6'h2B, 1'b0, 1'b1, 1'b0, 0, 1'b0);  // hit way0
    do_req(6'h33, 1'b0, 1'b0, 1'b1, 1, 1'b0);  // same set, way1 empty
    do_req(6'h2B, 1'b0, 1'b1, 1'b0, 0, 1'b0);  // hit way0 -> LRU=1
    do_req(6'h3B, 1'b0, 1'b0, 1'b1, 2, 1'b0);  // evict way1
    do_req(6'h2B, 1'b1, 1'b1, 1'b0, 0, 1'b0);  // write hit
    do_req(6'h10, 1'b1, 1'b0, 1'b0, 3, 1'b0);  // write miss, allocate way0
    do_req(6'h3B, 1'b0, 1'b1, 1'b1, 0, 1'b0);  // hit way1 -> LRU=0
    do_req(6'h33, 1'b0, 1'b0, 1'b0, 0, 1'b0);  // evicted earlier, victim way0
    do_req(6'h10, 1'b0, 1'b1, 1'b0, 0, 1'b1);  // req_valid held across transactions
    do_req(6'h10, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    do_req(6'h10, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("accept_count", accepts, n_req);
    chk("queue_empty", sbq.size(), 0);

    // Reset while a fill is outstanding
    req_valid = 1'b1; req_addr = 6'h20; req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_req++;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("rf_mem_req_up", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_mem_req_drop", mem_req, 0);
    chk("rf_counts", {hit_count, miss_count}, 0);
    chk("rf_ready", req_ready, 0);
    exp_hits = 0; exp_miss = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(6'h20, 1'b0, 1'b0, 1'b0, 1, 1'b0);  // not installed before reset
    do_req(6'h2B, 1'b0, 1'b0, 1'b0, 0, 1'b0);  // cache contents cleared
    repeat (3) @(negedge clk);
    chk("accept_count_final", accepts, n_req);
    chk("queue_empty_final", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
